// File: rtl/tank_pkg.sv
// Shared types and screen geometry for the tank game datapath blocks.
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_RIGHT = 3'b010,
    DIR_LEFT  = 3'b011,
    DIR_DOWN  = 3'b100
  } dir_t;

  typedef enum logic [1:0] {
    HIT_IDLE = 2'b00,
    HIT_FLY  = 2'b01,
    HIT_TANK = 2'b10,
    HIT_WALL = 2'b11
  } hit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLYING,
    ST_IMPACT
  } state_t;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int TANK_SZ    = 32;
  localparam int BULLET_SZ  = 8;
  localparam int MUZZLE_OFS = 12;

  function automatic logic dir_valid(input logic [2:0] d);
    return (d == DIR_UP) || (d == DIR_RIGHT) || (d == DIR_LEFT) || (d == DIR_DOWN);
  endfunction

endpackage

// File: rtl/bullet_ctrl_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse (3 Clk edge-to-pulse).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 3'b000;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], din};
      pulse <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/bullet_ctrl.sv
// Per-tank bullet engine: spawn on fire, advance per frame, detect impacts, hold, re-arm.
// Optional edge reflection is enabled by defining BULLET_BOUNCE_EN.
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter int SPEED       = 4,
  parameter int HOLD_FRAMES = 8
`ifdef BULLET_BOUNCE_EN
  ,
  parameter int MAX_BOUNCES = 3
`endif
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] tankX,
  input  logic [9:0] tankY,
  input  logic [2:0] tank_dir,
  input  logic [9:0] enemyX,
  input  logic [9:0] enemyY,
  input  logic       enemy_alive,
  input  logic       wall_hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic [1:0] hit,
  output logic       is_bullet,
  output logic       enemy_kill
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES) + 1;
  localparam logic signed [10:0] STEP  = 11'(SPEED);
  localparam logic signed [10:0] X_LIM = 11'(SCREEN_W - BULLET_SZ - 1);
  localparam logic signed [10:0] Y_LIM = 11'(SCREEN_H - BULLET_SZ - 1);

  logic frame_tick, fire_pulse;

  edge_sync u_frame_sync (.clk(Clk), .rst_n(Reset_n), .din(frame_clk), .pulse(frame_tick));
  edge_sync u_fire_sync  (.clk(Clk), .rst_n(Reset_n), .din(fire),      .pulse(fire_pulse));

  state_t            state, state_nx;
  dir_t              dir_q, dir_nx;
  hit_t              hit_q, hit_nx;
  logic [9:0]        bx_q, by_q, bx_nx, by_nx;
  logic [HOLD_W-1:0] hold_q, hold_nx;
  logic              kill_q, kill_nx;

`ifdef BULLET_BOUNCE_EN
  localparam int BNC_W = $clog2(MAX_BOUNCES + 1);
  logic [BNC_W-1:0]  bnc_q, bnc_nx;

  function automatic logic [9:0] clamp(input logic signed [10:0] v, input logic signed [10:0] lim);
    if (v < 0)        return 10'd0;
    else if (v > lim) return lim[9:0];
    else              return v[9:0];
  endfunction

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return d;
    endcase
  endfunction
`endif

  // Candidate next position, signed so a step past 0 goes negative instead of wrapping.
  logic signed [10:0] px, py, nx, ny;
  logic               out_x, out_y, overlap;

  always_comb begin
    px = signed'({1'b0, bx_q});
    py = signed'({1'b0, by_q});
    nx = px;
    ny = py;
    case (dir_q)
      DIR_UP:    ny = py - STEP;
      DIR_DOWN:  ny = py + STEP;
      DIR_RIGHT: nx = px + STEP;
      DIR_LEFT:  nx = px - STEP;
      default:   ;
    endcase
    out_x = (nx < 0) || (nx > X_LIM);
    out_y = (ny < 0) || (ny > Y_LIM);
  end

  assign overlap = ({1'b0, bx_q} <= {1'b0, enemyX} + 11'(TANK_SZ - 1)) &&
                   ({1'b0, bx_q} + 11'(BULLET_SZ - 1) >= {1'b0, enemyX}) &&
                   ({1'b0, by_q} <= {1'b0, enemyY} + 11'(TANK_SZ - 1)) &&
                   ({1'b0, by_q} + 11'(BULLET_SZ - 1) >= {1'b0, enemyY});

  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    hit_nx   = hit_q;
    bx_nx    = bx_q;
    by_nx    = by_q;
    hold_nx  = hold_q;
    kill_nx  = 1'b0;
`ifdef BULLET_BOUNCE_EN
    bnc_nx   = bnc_q;
`endif
    case (state)
      ST_IDLE: begin
        if (fire_pulse && dir_valid(tank_dir)) begin
          state_nx = ST_FLYING;
          dir_nx   = dir_t'(tank_dir);
          hit_nx   = HIT_FLY;
          bx_nx    = tankX + 10'(MUZZLE_OFS);
          by_nx    = tankY + 10'(MUZZLE_OFS);
`ifdef BULLET_BOUNCE_EN
          bnc_nx   = '0;
`endif
        end
      end
      ST_FLYING: begin
        if (frame_tick) begin
          if (enemy_alive && overlap) begin
            state_nx = ST_IMPACT;
            hit_nx   = HIT_TANK;
            hold_nx  = '0;
            kill_nx  = 1'b1;
          end else if (wall_hit) begin
            state_nx = ST_IMPACT;
            hit_nx   = HIT_WALL;
            hold_nx  = '0;
          end else if (out_x || out_y) begin
`ifdef BULLET_BOUNCE_EN
            if (bnc_q == BNC_W'(MAX_BOUNCES)) begin
              state_nx = ST_IMPACT;
              hit_nx   = HIT_WALL;
              hold_nx  = '0;
            end else begin
              dir_nx = reverse_dir(dir_q);
              bx_nx  = clamp(nx, X_LIM);
              by_nx  = clamp(ny, Y_LIM);
              bnc_nx = bnc_q + 1'b1;
            end
`else
            state_nx = ST_IMPACT;
            hit_nx   = HIT_WALL;
            hold_nx  = '0;
`endif
          end else begin
            bx_nx = nx[9:0];
            by_nx = ny[9:0];
          end
        end
      end
      ST_IMPACT: begin
        if (frame_tick) begin
          if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
            state_nx = ST_IDLE;
            hit_nx   = HIT_IDLE;
            hold_nx  = '0;
          end else begin
            hold_nx = hold_q + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= ST_IDLE;
      dir_q  <= DIR_NONE;
      hit_q  <= HIT_IDLE;
      bx_q   <= '0;
      by_q   <= '0;
      hold_q <= '0;
      kill_q <= 1'b0;
`ifdef BULLET_BOUNCE_EN
      bnc_q  <= '0;
`endif
    end else begin
      state  <= state_nx;
      dir_q  <= dir_nx;
      hit_q  <= hit_nx;
      bx_q   <= bx_nx;
      by_q   <= by_nx;
      hold_q <= hold_nx;
      kill_q <= kill_nx;
`ifdef BULLET_BOUNCE_EN
      bnc_q  <= bnc_nx;
`endif
    end
  end

  assign bulletX    = bx_q;
  assign bulletY    = by_q;
  assign hit        = hit_q;
  assign enemy_kill = kill_q;
  assign is_bullet  = (hit_q == HIT_FLY) &&
                      (DrawX >= bx_q) && ({1'b0, DrawX} <= {1'b0, bx_q} + 11'(BULLET_SZ - 1)) &&
                      (DrawY >= by_q) && ({1'b0, DrawY} <= {1'b0, by_q} + 11'(BULLET_SZ - 1));

endmodule
